// File: rtl/conv_window_reader_pkg.sv
// Shared definitions for the 3x3 convolution window reader and its tap-offset generator.
package conv_window_reader_pkg;

    localparam int unsigned KTAPS          = 9;
    localparam int unsigned KDIM           = 3;
    localparam int unsigned ADDR_W_DEFAULT = 11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StIssue,
        StDone
    } rd_state_e;

    // Distance from a window's top-left pixel to its bottom-right pixel.
    function automatic int unsigned br_distance(input int unsigned img_w);
        return (KDIM - 1) * img_w + (KDIM - 1);
    endfunction

endpackage

// File: rtl/conv_tap_offset.sv
// Walks the 9 kernel taps of one window in raster order, producing the address offset
// from the window base incrementally (no multiplier).
module conv_tap_offset
    import conv_window_reader_pkg::*;
#(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_off,
    output logic [3:0]        o_tap_idx,
    output logic              o_last
);

    logic [1:0]        r_kx;
    logic [3:0]        r_tap;
    logic [ADDR_W-1:0] r_off;
    logic              w_last;

    assign w_last    = (r_tap == 4'(KTAPS - 1));
    assign o_off     = r_off;
    assign o_tap_idx = r_tap;
    assign o_last    = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kx  <= '0;
            r_tap <= '0;
            r_off <= '0;
        end else if (i_clear || (i_advance && w_last)) begin
            r_kx  <= '0;
            r_tap <= '0;
            r_off <= '0;
        end else if (i_advance) begin
            r_tap <= r_tap + 4'd1;
            if (r_kx == 2'(KDIM - 1)) begin
                // Jump from the end of one kernel row to the start of the next.
                r_kx  <= '0;
                r_off <= r_off + ADDR_W'(IMG_W - 2);
            end else begin
                r_kx  <= r_kx + 2'd1;
                r_off <= r_off + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_window_reader.sv
// Read-side frame walker: issues 9 tap reads per valid 3x3 window, gated so it never
// overtakes the pixel writer, and tags each returning RAM beat for the MAC.
module conv_window_reader
    import conv_window_reader_pkg::*;
#(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_wr_count,
    input  logic              i_stall,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_dv,
    output logic [3:0]        o_tap_idx,
    output logic              o_last_tap,
    output logic [ADDR_W-1:0] o_out_row,
    output logic [ADDR_W-1:0] o_out_col,
    output logic              o_busy,
    output logic              o_done
);

    rd_state_e         r_state;
    rd_state_e         w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;

    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_off;
    logic [3:0]        w_tap_idx;
    logic              w_tap_last;
    logic              w_ready;
    logic              w_issue;
    logic              w_clear;
    logic              w_win_end;
    logic              w_last_col;
    logic              w_last_win;

    logic              r_dv;
    logic [3:0]        r_tap_idx;
    logic              r_last_tap;
    logic [ADDR_W-1:0] r_out_row;
    logic [ADDR_W-1:0] r_out_col;

    // Writer count is "pixels written", so the bottom-right tap is safe once count > BR.
    assign w_br       = r_base + ADDR_W'(br_distance(IMG_W));
    assign w_ready    = (i_wr_count > w_br);
    assign w_issue    = (r_state == StIssue) && !i_stall && w_ready;
    assign w_clear    = (r_state == StIdle) && i_start;
    assign w_win_end  = w_issue && w_tap_last;
    assign w_last_col = (r_col == ADDR_W'(IMG_W - 3));
    assign w_last_win = w_last_col && (r_row == ADDR_W'(IMG_H - 3));

    conv_tap_offset #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_tap_offset (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_clear),
        .i_advance (w_issue),
        .o_off     (w_off),
        .o_tap_idx (w_tap_idx),
        .o_last    (w_tap_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StWait;
            StWait:  if (w_ready) w_state_next = StIssue;
            StIssue: begin
                if (w_win_end) begin
                    w_state_next = w_last_win ? StDone : StWait;
                end else if (!w_ready) begin
                    // Writer fell back: park in WAIT with the tap position held.
                    w_state_next = StWait;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_clear) begin
            r_base <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_win_end && !w_last_win) begin
            if (w_last_col) begin
                // Skip the two right-edge columns that cannot host a window.
                r_base <= r_base + ADDR_W'(3);
                r_col  <= '0;
                r_row  <= r_row + ADDR_W'(1);
            end else begin
                r_base <= r_base + ADDR_W'(1);
                r_col  <= r_col + ADDR_W'(1);
            end
        end
    end

    // One-cycle delay matching the synchronous RAM read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dv       <= 1'b0;
            r_tap_idx  <= '0;
            r_last_tap <= 1'b0;
            r_out_row  <= '0;
            r_out_col  <= '0;
        end else begin
            r_dv       <= w_issue;
            r_tap_idx  <= w_issue ? w_tap_idx : 4'd0;
            r_last_tap <= w_issue && w_tap_last;
            r_out_row  <= w_issue ? r_row : '0;
            r_out_col  <= w_issue ? r_col : '0;
        end
    end

    assign o_rd_en    = w_issue;
    assign o_rd_addr  = w_issue ? (r_base + w_off) : '0;
    assign o_dv       = r_dv;
    assign o_tap_idx  = r_tap_idx;
    assign o_last_tap = r_last_tap;
    assign o_out_row  = r_out_row;
    assign o_out_col  = r_out_col;
    assign o_busy     = (r_state == StWait) || (r_state == StIssue);
    assign o_done     = (r_state == StDone);

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader on a 4x4 image: address order, tagging, writer
// gating, stall, start-while-busy and mid-frame reset.
module tb_conv_window_reader;

    localparam int unsigned AW = 11;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_wr_count;
    logic          i_stall;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_dv;
    logic [3:0]    o_tap_idx;
    logic          o_last_tap;
    logic [AW-1:0] o_out_row;
    logic [AW-1:0] o_out_col;
    logic          o_busy;
    logic          o_done;

    conv_window_reader #(
        .IMG_W  (4),
        .IMG_H  (4),
        .ADDR_W (AW)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (i_start),
        .i_wr_count (i_wr_count),
        .i_stall    (i_stall),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .o_dv       (o_dv),
        .o_tap_idx  (o_tap_idx),
        .o_last_tap (o_last_tap),
        .o_out_row  (o_out_row),
        .o_out_col  (o_out_col),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled on the falling edge.
    logic [AW-1:0] rd_q[$];
    int            rd_cyc[$];
    logic [3:0]    dv_tap[$];
    logic          dv_last[$];
    logic [AW-1:0] dv_row[$];
    logic [AW-1:0] dv_col[$];
    int            dv_cyc[$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (o_rd_en) begin
            rd_q.push_back(o_rd_addr);
            rd_cyc.push_back(cyc);
        end
        if (o_dv) begin
            dv_tap.push_back(o_tap_idx);
            dv_last.push_back(o_last_tap);
            dv_row.push_back(o_out_row);
            dv_col.push_back(o_out_col);
            dv_cyc.push_back(cyc);
        end
        if (o_done) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_stall    = 1'b0;
        i_wr_count = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!o_done && n < bound) begin
            step(1);
            n++;
        end
        check_eq({tag, "_done_seen"}, {31'd0, o_done}, 32'd1);
        step(1);
        check_eq({tag, "_busy_after_done"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_addr(input string tag, input logic [AW-1:0] addr, input int nth,
                             input int bound);
        int seen = 0;
        int n    = 0;
        while (seen < nth && n < bound) begin
            step(1);
            if (o_rd_en && o_rd_addr == addr) seen++;
            n++;
        end
        check_eq({tag, "_addr_reached"}, seen, nth);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rd_en"}, {31'd0, o_rd_en}, 32'd0);
        check_eq({tag, "_rd_addr"}, {21'd0, o_rd_addr}, 32'd0);
        check_eq({tag, "_dv"}, {31'd0, o_dv}, 32'd0);
        check_eq({tag, "_tap_idx"}, {28'd0, o_tap_idx}, 32'd0);
        check_eq({tag, "_last_tap"}, {31'd0, o_last_tap}, 32'd0);
        check_eq({tag, "_out_row"}, {21'd0, o_out_row}, 32'd0);
        check_eq({tag, "_out_col"}, {21'd0, o_out_col}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, o_done}, 32'd0);
    endtask

    int first_addr[9];
    int last_addr[9];
    int rb;
    int db;
    int d0;
    int k;

    initial begin
        first_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        last_addr  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_stall    = 1'b0;
        i_wr_count = '0;
        step(2);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        step(1);

        // Tests 1 and 2: full pass with all data written.
        i_wr_count = AW'(16);
        rb = rd_q.size();
        db = dv_tap.size();
        d0 = done_cnt;
        pulse_start();
        check_eq("t1_busy_after_start", {31'd0, o_busy}, 32'd1);
        wait_done("t2", 300);
        step(20);
        check_eq("t2_rd_count", rd_q.size() - rb, 36);
        check_eq("t2_dv_count", dv_tap.size() - db, 36);
        check_eq("t2_done_count", done_cnt - d0, 1);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("t1_addr%0d", i), {21'd0, rd_q[rb + i]}, first_addr[i]);
            check_eq($sformatf("t2_last_addr%0d", i), {21'd0, rd_q[rb + 27 + i]}, last_addr[i]);
        end
        check_eq("t1_dv_latency", dv_cyc[db] - rd_cyc[rb], 1);
        check_eq("t1_consecutive", rd_cyc[rb + 8] - rd_cyc[rb], 8);
        for (int i = 0; i < 36; i++) begin
            check_eq($sformatf("t2_tap%0d", i), {28'd0, dv_tap[db + i]}, i % 9);
            check_eq($sformatf("t2_last%0d", i), {31'd0, dv_last[db + i]},
                     (i % 9 == 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_row%0d", i), {21'd0, dv_row[db + i]}, (i / 9) / 2);
            check_eq($sformatf("t2_col%0d", i), {21'd0, dv_col[db + i]}, (i / 9) % 2);
        end

        // Test 3: writer gating on the first window (BR = 10).
        do_reset();
        i_wr_count = AW'(10);
        rb = rd_q.size();
        pulse_start();
        step(20);
        check_eq("t3_no_reads", rd_q.size() - rb, 0);
        check_eq("t3_busy_waiting", {31'd0, o_busy}, 32'd1);
        i_wr_count = AW'(11);
        k = cyc;
        begin
            int n = 0;
            while (rd_q.size() == rb && n < 20) begin
                step(1);
                n++;
            end
        end
        check_eq("t3_first_read_seen", rd_q.size() - rb, 1);
        check_eq("t3_first_read_cycle", rd_cyc[rb], k + 1);
        check_eq("t3_first_read_addr", {21'd0, rd_q[rb]}, 0);
        i_wr_count = AW'(16);
        wait_done("t3", 300);

        // Test 4: 3-cycle stall right after tap 4 has issued.
        do_reset();
        i_wr_count = AW'(16);
        rb = rd_q.size();
        db = dv_tap.size();
        pulse_start();
        wait_addr("t4", AW'(5), 1, 50);
        step(1);
        i_stall = 1'b1;
        step(3);
        i_stall = 1'b0;
        wait_done("t4", 300);
        check_eq("t4_rd_count", rd_q.size() - rb, 36);
        check_eq("t4_stall_gap", rd_cyc[rb + 5] - rd_cyc[rb + 4], 4);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("t4_addr%0d", i), {21'd0, rd_q[rb + i]}, first_addr[i]);
            check_eq($sformatf("t4_tap%0d", i), {28'd0, dv_tap[db + i]}, i);
        end

        // Test 5: second start while busy is ignored.
        do_reset();
        i_wr_count = AW'(16);
        rb = rd_q.size();
        d0 = done_cnt;
        pulse_start();
        step(5);
        pulse_start();
        wait_done("t5", 300);
        step(30);
        check_eq("t5_rd_count", rd_q.size() - rb, 36);
        check_eq("t5_done_count", done_cnt - d0, 1);
        check_eq("t5_idle_busy", {31'd0, o_busy}, 32'd0);

        // Test 6: reset during tap 3 of window 2 (address 5, second occurrence).
        do_reset();
        i_wr_count = AW'(16);
        pulse_start();
        wait_addr("t6", AW'(5), 2, 60);
        check_eq("t6_dv_pending", {31'd0, o_dv}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        step(2);
        rst_n = 1'b1;
        step(1);
        rb = rd_q.size();
        db = dv_tap.size();
        pulse_start();
        begin
            int n = 0;
            while (dv_tap.size() == db && n < 30) begin
                step(1);
                n++;
            end
        end
        check_eq("t6_restart_seen", dv_tap.size() - db, 1);
        check_eq("t6_restart_addr", {21'd0, rd_q[rb]}, 0);
        check_eq("t6_restart_tap", {28'd0, dv_tap[db]}, 0);
        wait_done("t6", 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_window_reader.md
Name: conv_window_reader

Overview:
- Read-side counterpart of the pixel write-address counter.
- The writer fills the frame buffer (2^ADDR_W pixels, raster order) one pixel per push and exposes its running count.
- This block walks the same buffer as the reader. For every valid 3x3 convolution window it issues 9 tap read addresses to the synchronous-read frame RAM, kernel raster order, never overtaking the writer.
- It tags each returning data beat for the downstream MAC.

Parameters:
- IMG_W, 32, image width in pixels (>=3)
- IMG_H, 32, image height in pixels (>=3)
- ADDR_W, 11, buffer address width; IMG_W*IMG_H < 2^ADDR_W, so the writer count never wraps within a frame

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: begin one frame pass
- wr_count  input  ADDR_W  writer address counter = number of pixels written so far
- stall  input  1  downstream back-pressure; hold issue while high
- rd_en  output  1  RAM read enable, one per tap
- rd_addr  output  ADDR_W  RAM read address
- dv  output  1  RAM data valid (rd_en delayed 1 cycle)
- tap_idx  output  4  0..8 tap index aligned with dv
- last_tap  output  1  dv beat is tap 8 of a window
- out_row  output  ADDR_W  output-pixel row of the current dv beat (0..IMG_H-3)
- out_col  output  ADDR_W  output-pixel column of the current dv beat (0..IMG_W-3)
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse after the last tap of the frame is issued

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; all counters 0.
- FSM states: IDLE, WAIT, ISSUE, DONE.
  - IDLE: on start go to WAIT; base=0, row=0, col=0, tap=0; busy=1 from the next cycle.
  - WAIT: window bottom-right address BR = base + 2*IMG_W + 2. Go to ISSUE in the cycle after wr_count > BR.
  - ISSUE:
    - Each cycle with stall=0: rd_en=1, rd_addr=base+off, tap advances.
    - stall=1: rd_en=0; tap, off and base hold.
    - After tap 8 issues: if the window was the last one (row=IMG_H-3, col=IMG_W-3), go to DONE; otherwise advance the window and go to WAIT.
  - DONE: done=1 for one cycle, busy=0, back to IDLE.
- Address arithmetic (no multipliers):
  - Tap offset off starts at 0; +1 within a kernel row; +(IMG_W-2) when kx wraps 2->0.
  - Window advance: base+1, col+1. At col=IMG_W-3: base+3, col=0, row+1.
  - All sums are ADDR_W bits; overflow is impossible under the parameter constraint.
- Data tagging: dv, tap_idx, last_tap, out_row, out_col are registered copies of the issue-cycle values, delayed exactly 1 cycle to match RAM read latency. stall does not affect beats already issued.
- start while busy: ignored.
- wr_count regressing (writer reset mid-frame): reader stays or returns to waiting in WAIT. Taps already issued are not retracted.
- reset mid-operation: immediate return to IDLE; any pending dv is dropped.
- Throughput: 9 cycles per window when unstalled and the data is already written. WAIT costs 1 cycle per window.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/ISSUE/DONE), KTAPS=9, KDIM=3, and the ADDR_W default shared with the write counter.
- One natural sub-module: conv_tap_offset. It holds the kx/ky counters and the incremental off register, with advance/clear inputs and tap_idx/last outputs. The parent owns the FSM, base/row/col, the writer-gating compare, and the output delay stage.

Test Plan:
1. IMG_W=IMG_H=4, wr_count=16, start -> first window rd_addr 0,1,2,4,5,6,8,9,10 on consecutive rd_en cycles; dv/tap_idx 0..8 one cycle later; last_tap with tap 8; out_row=out_col=0.
2. Same config, full pass -> exactly 36 rd_en. Last window rd_addr 5,6,7,9,10,11,13,14,15 with out_row=out_col=1. done pulses once; busy then falls.
3. wr_count held at 10 after start -> no rd_en. Raise wr_count to 11 -> first rd_en on the next cycle.
4. stall=1 for 3 cycles after tap 4 -> rd_en low for 3 cycles, then rd_addr resumes at 6 (tap 5). Tap sequence is unbroken; total rd_en count is unchanged.
5. Second start pulse while busy -> ignored; frame completes with 36 reads and a single done.
6. reset low during tap 3 of window 2 -> all outputs 0 asynchronously. After release, start yields rd_addr 0 again.
